// File: rtl/pred_ctx_pkg.sv
// Shared definitions for the predicate context sequencer.
// Holds the context word layout, the NOP word, routing select constants,
// FU predicate source codes and the sequencer state encoding.
package pred_ctx_pkg;

  localparam int unsigned CTX_W = 47;

  // Context word field positions (MSB:LSB)
  localparam int unsigned IN_SEL_MSB  = 46;
  localparam int unsigned IN_SEL_LSB  = 38;
  localparam int unsigned PUT_IN_MSB  = 37;
  localparam int unsigned PUT_IN_LSB  = 32;
  localparam int unsigned PUT_OUT_MSB = 31;
  localparam int unsigned PUT_OUT_LSB = 26;
  localparam int unsigned PRED_MSB    = 25;
  localparam int unsigned PRED_LSB    = 20;
  localparam int unsigned SEND_MSB    = 19;
  localparam int unsigned SEND_LSB    = 14;
  localparam int unsigned OUT_SEL_MSB = 13;
  localparam int unsigned OUT_SEL_LSB = 5;
  localparam int unsigned PE2FU_MSB   = 4;
  localparam int unsigned PE2FU_LSB   = 1;
  localparam int unsigned WB_BIT      = 0;

  typedef struct packed {
    logic [8:0] in_sel;
    logic [5:0] put_in;
    logic [5:0] put_out;
    logic [5:0] pred;
    logic [5:0] send;
    logic [8:0] out_sel;
    logic [3:0] pe2fu;
    logic       wb;
  } ctx_word_t;

  // The register file writes put_in on every negedge, so idle words target
  // the reserved scratch register instead of a live one.
  localparam logic [5:0] SCRATCH_IDX = 6'd63;

  localparam ctx_word_t NOP_WORD = '{
    in_sel:  '0,
    put_in:  SCRATCH_IDX,
    put_out: SCRATCH_IDX,
    pred:    '0,
    send:    '0,
    out_sel: '0,
    pe2fu:   '0,
    wb:      1'b0
  };

  // One-hot input / output mux selects
  localparam logic [8:0] SEL_EDGE9  = 9'b000001000;
  localparam logic [8:0] SEL_EDGE11 = 9'b000000100;
  localparam logic [8:0] SEL_EDGE12 = 9'b000000001;
  localparam logic [8:0] SEL_BUS    = 9'b000010000;

  // FU predicate source codes
  localparam logic [3:0] PE2FU_REG    = 4'b0000;
  localparam logic [3:0] PE2FU_EDGE9  = 4'b0100;
  localparam logic [3:0] PE2FU_EDGE11 = 4'b0011;
  localparam logic [3:0] PE2FU_EDGE12 = 4'b0001;
  localparam logic [3:0] PE2FU_BUS    = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Input-mux write and FU write-back aimed at the same register.
  function automatic logic is_conflict(input ctx_word_t w);
    return w.wb && (w.put_in == w.put_out) && (w.in_sel != '0);
  endfunction

endpackage

// File: rtl/pred_ctx_mem.sv
// Context memory: CTX_DEPTH x 47-bit register array.
// Ports: CLK; we/wr_addr/wr_data synchronous write port;
//        rd_addr/rd_data combinational read port.
module pred_ctx_mem
  import pred_ctx_pkg::*;
#(
  parameter int unsigned CTX_DEPTH = 16,
  parameter int unsigned CTX_AW    = 4
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [CTX_AW-1:0] wr_addr,
  input  ctx_word_t         wr_data,
  input  logic [CTX_AW-1:0] rd_addr,
  output ctx_word_t         rd_data
);

  ctx_word_t mem [CTX_DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pred_ctx_seq.sv
// Per-PE predicate context sequencer. Stores a program of predicate-routing
// words and, on start, issues one word per cycle to the predicate register
// file control bus, optionally repeating the program loop_cnt extra times.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   cfg_we/addr/data    context write port (ignored while busy)
//   ctx_last, loop_cnt  program length and extra passes, sampled at start
//   start, abort        begin issuing / stop immediately
//   busy, done          running / one-cycle completion pulse
//   conflict            issued word writes the same register from both paths
//   control_*           registered control word fields to the register file
module pred_ctx_seq
  import pred_ctx_pkg::*;
#(
  parameter int unsigned CTX_DEPTH = 16,
  parameter int unsigned CTX_AW    = 4,
  parameter int unsigned LOOP_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [CTX_W-1:0]  cfg_data,
  input  logic [CTX_AW-1:0] ctx_last,
  input  logic [LOOP_W-1:0] loop_cnt,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              conflict,
  output logic [8:0]        control_in_p,
  output logic [5:0]        control_put_in_p,
  output logic [5:0]        control_put_out_p,
  output logic              write_back_p,
  output logic [5:0]        control_pred,
  output logic [5:0]        control_send_p,
  output logic [8:0]        control_out_p,
  output logic [3:0]        control_pe2fu_p
);

  seq_state_t        state_q, state_d;
  logic [CTX_AW-1:0] pc_q, pc_d;
  logic [CTX_AW-1:0] last_q, last_d;
  logic [LOOP_W-1:0] iter_q, iter_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  ctx_word_t         word_q, word_d;
  logic              conflict_q;

  logic              mem_we;
  logic [CTX_AW-1:0] rd_addr;
  ctx_word_t         rd_data;

  assign mem_we  = cfg_we && !RST && (state_q != ST_RUN);
  assign rd_addr = (state_q == ST_RUN) ? pc_q : '0;

  pred_ctx_mem #(
    .CTX_DEPTH (CTX_DEPTH),
    .CTX_AW    (CTX_AW)
  ) u_mem (
    .CLK     (CLK),
    .we      (mem_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register and registered datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      iter_q     <= '0;
      last_q     <= '0;
      loop_q     <= '0;
      word_q     <= NOP_WORD;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      last_q     <= last_d;
      loop_q     <= loop_d;
      word_q     <= word_d;
      conflict_q <= is_conflict(word_d);
    end
  end

  // Next-state logic. In RUN, pc_q==0 means the word just issued was
  // ctx[last]: pc wraps to 0 after issuing last, and stays 0 when last==0.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if ((pc_q == '0) && (iter_q == loop_q)) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next issued word and counters
  always_comb begin
    word_d = NOP_WORD;
    pc_d   = pc_q;
    iter_d = iter_q;
    last_d = last_q;
    loop_d = loop_q;
    if (abort) begin
      pc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pc_d = '0;
          if (start) begin
            last_d = ctx_last;
            loop_d = loop_cnt;
            iter_d = '0;
            word_d = rd_data;
            pc_d   = (ctx_last == '0) ? '0 : CTX_AW'(1);
          end
        end
        ST_RUN: begin
          if (pc_q == '0) begin
            if (iter_q == loop_q) begin
              pc_d = '0;
            end else begin
              word_d = rd_data;
              pc_d   = (last_q == '0) ? '0 : CTX_AW'(1);
              iter_d = iter_q + 1'b1;
            end
          end else begin
            word_d = rd_data;
            pc_d   = (pc_q == last_q) ? '0 : pc_q + 1'b1;
          end
        end
        default: begin
          pc_d = '0;
        end
      endcase
    end
  end

  // Outputs
  assign busy              = (state_q == ST_RUN);
  assign done              = (state_q == ST_DONE);
  assign conflict          = conflict_q;
  assign control_in_p      = word_q.in_sel;
  assign control_put_in_p  = word_q.put_in;
  assign control_put_out_p = word_q.put_out;
  assign write_back_p      = word_q.wb;
  assign control_pred      = word_q.pred;
  assign control_send_p    = word_q.send;
  assign control_out_p     = word_q.out_sel;
  assign control_pe2fu_p   = word_q.pe2fu;

endmodule
